// File: rtl/n64_pkg.sv
// Shared types and constants for the N64 controller line receiver.
// Status word layout matches the controller's 32-bit button/stick report.
package n64_pkg;

    typedef struct packed {
        logic       a;
        logic       b;
        logic       z;
        logic       start;
        logic [3:0] dpad;     // gray U/D/L/R
        logic [1:0] unused;
        logic       l;
        logic       r;
        logic [3:0] cpad;     // yellow U/D/L/R
        logic [7:0] x;
        logic [7:0] y;
    } n64_status_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_HIGH,
        S_LOW,
        S_DRAIN
    } n64_state_t;

    localparam logic [8:0] N64_HEADER       = 9'b000000011;
    localparam int         N64_FRAME_BITS   = 41;
    localparam int         N64_PAYLOAD_BITS = 32;

    // Floor of clk_hz*ns/1e9, clamped to the 16-bit phase counter range.
    function automatic logic [15:0] ns_to_cycles(input longint unsigned clk_hz,
                                                 input longint unsigned ns);
        longint unsigned c;
        c = (clk_hz * ns) / 64'd1_000_000_000;
        return (c > 64'd65535) ? 16'hFFFF : c[15:0];
    endfunction

endpackage

// File: rtl/n64_sync_edge.sv
// Two-flop synchronizer for the asynchronous controller line plus registered
// rise/fall strobes; edges reach the FSM three clocks after din moves.
module n64_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            s3   <= 1'b1;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
            fall <= ~s2 & s3;
        end
    end

    assign lvl = s3;

endmodule

// File: rtl/n64_rx.sv
// N64 controller response receiver: measures high-phase widths to decode
// 41 bits, checks the 9-bit header and publishes the 32-bit status word.
module n64_rx
    import n64_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned THRESH_NS    = 1650,
    parameter int unsigned START_MIN_NS = 3000,
    parameter int unsigned TIMEOUT_NS   = 10000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    output logic [31:0] data,
    output logic        valid,
    output logic        err
);

    localparam logic [15:0] THRESH_C    = ns_to_cycles(64'(CLK_HZ), 64'(THRESH_NS));
    localparam logic [15:0] START_MIN_C = ns_to_cycles(64'(CLK_HZ), 64'(START_MIN_NS));
    localparam logic [15:0] TIMEOUT_C   = ns_to_cycles(64'(CLK_HZ), 64'(TIMEOUT_NS));
    localparam logic [5:0]  LAST_BIT    = 6'(N64_FRAME_BITS - 1);

    logic        lvl, rise, fall;
    n64_state_t  state;
    logic [15:0] cnt;
    logic [5:0]  bit_cnt;
    logic [N64_FRAME_BITS-1:0] sh;
    n64_status_t stat;

    logic [15:0] cnt_inc;
    logic [N64_FRAME_BITS-1:0] sh_next;
    logic        timeout;

    n64_sync_edge u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .lvl  (lvl),
        .rise (rise),
        .fall (fall)
    );

    assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    assign sh_next = {sh[N64_FRAME_BITS-2:0], (cnt > THRESH_C)};
    assign timeout = (cnt >= TIMEOUT_C);
    assign data    = stat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            sh      <= '0;
            stat    <= '0;
            valid   <= 1'b0;
            err     <= 1'b0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            cnt   <= (rise || fall) ? 16'd0 : cnt_inc;
            case (state)
                S_IDLE: begin
                    if (fall) begin
                        state   <= S_START;
                        bit_cnt <= '0;
                    end
                end
                S_START: begin
                    // A short low is treated as line noise and dropped silently.
                    if (rise) begin
                        state <= (cnt >= START_MIN_C) ? S_HIGH : S_IDLE;
                    end else if (timeout) begin
                        err   <= 1'b1;
                        cnt   <= '0;
                        state <= S_DRAIN;
                    end
                end
                S_HIGH: begin
                    if (fall) begin
                        sh      <= sh_next;
                        bit_cnt <= bit_cnt + 6'd1;
                        state   <= S_LOW;
                        if (bit_cnt == LAST_BIT) begin
                            if (sh_next[N64_FRAME_BITS-1:N64_PAYLOAD_BITS] == N64_HEADER) begin
                                stat  <= n64_status_t'(sh_next[N64_PAYLOAD_BITS-1:0]);
                                valid <= 1'b1;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end else if (timeout) begin
                        err   <= 1'b1;
                        cnt   <= '0;
                        state <= S_DRAIN;
                    end
                end
                S_LOW: begin
                    if (rise) begin
                        state <= (bit_cnt < 6'(N64_FRAME_BITS)) ? S_HIGH : S_IDLE;
                    end else if (timeout) begin
                        err   <= 1'b1;
                        cnt   <= '0;
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Wait for a full timeout of continuous idle-high before rearming.
                    if (!lvl) begin
                        cnt <= '0;
                    end else if (timeout) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_n64_rx.sv
// Self-checking bench for n64_rx: a transmitter model drives din and a
// frame-level reference model predicts the published status word.
module tb_n64_rx;
    import n64_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b1;
    logic [31:0] data;
    logic        valid;
    logic        err;

    n64_rx dut (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .data  (data),
        .valid (valid),
        .err   (err)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Pulse monitor, sampled on the falling edge away from DUT updates.
    int          n_valid = 0;
    int          n_err = 0;
    int          n_both = 0;
    int          n_bad_change = 0;
    logic [31:0] prev_data = 32'h0;
    time         err_t = 0;

    always @(negedge clk) begin
        if (valid) n_valid++;
        if (err) begin
            n_err++;
            err_t = $time;
        end
        if (valid && err) n_both++;
        if (!rst && (data !== prev_data) && !valid) n_bad_change++;
        prev_data = data;
    end

    // Reference model: expected published word, updated per whole frame.
    logic [31:0] exp_data = 32'h0;

    function automatic logic [40:0] make_frame(input logic [8:0] hdr, input logic [31:0] payload);
        return {hdr, payload};
    endfunction

    task automatic model_frame(input logic [40:0] bits);
        if (bits[40:32] == 9'b000000011) exp_data = bits[31:0];
    endtask

    // Transmitter: 4 us low start, then nbits bit cells, then line back high.
    task automatic send_bits(input logic [40:0] bits, input int nbits);
        @(negedge clk);
        din = 1'b0;
        #4000;
        for (int i = 40; i > 40 - nbits; i--) begin
            din = 1'b1;
            if (bits[i]) #2500; else #800;
            din = 1'b0;
            if (bits[i]) #1500; else #3200;
        end
        din = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            din = 1'($urandom);
            n_checks++;
            if (data !== 32'h0 || valid !== 1'b0 || err !== 1'b0) begin
                $display("FAIL reset: data=%h valid=%b err=%b, need 0/0/0", data, valid, err);
            end else n_pass++;
        end
        din = 1'b1;
        #1000;
        rst = 1'b0;
        #2000;
    endtask

    task automatic test_good_frame;
        int v0, e0;
        n64_status_t s;
        logic [40:0] f;
        s = '0;
        s.a = 1'b1;
        s.start = 1'b1;
        s.x = 8'h7F;
        s.y = 8'h80;
        f = make_frame(N64_HEADER, s);
        v0 = n_valid;
        e0 = n_err;
        send_bits(f, 41);
        model_frame(f);
        #2000;
        n_checks++;
        if (n_valid - v0 !== 1) $display("FAIL good_valid: pulses=%0d need 1", n_valid - v0);
        else n_pass++;
        n_checks++;
        if (data !== exp_data) $display("FAIL good_data: data=%h need %h", data, exp_data);
        else n_pass++;
        n_checks++;
        if (n_err - e0 !== 0) $display("FAIL good_err: pulses=%0d need 0", n_err - e0);
        else n_pass++;
    endtask

    task automatic test_bad_header;
        int v0, e0;
        logic [40:0] f;
        f = make_frame(9'b100000011, 32'hFFFF_FFFF);
        v0 = n_valid;
        e0 = n_err;
        send_bits(f, 41);
        model_frame(f);
        #2000;
        n_checks++;
        if (n_err - e0 !== 1) $display("FAIL badhdr_err: pulses=%0d need 1", n_err - e0);
        else n_pass++;
        n_checks++;
        if (n_valid - v0 !== 0) $display("FAIL badhdr_valid: pulses=%0d need 0", n_valid - v0);
        else n_pass++;
        n_checks++;
        if (data !== exp_data) $display("FAIL badhdr_data: data=%h need %h", data, exp_data);
        else n_pass++;
    endtask

    task automatic test_timeout;
        int v0, e0;
        time t_rise, dt;
        logic [40:0] f;
        f = make_frame(N64_HEADER, $urandom);
        v0 = n_valid;
        e0 = n_err;
        send_bits(f, 20);
        t_rise = $time;
        #12000;
        dt = err_t - t_rise;
        n_checks++;
        if (n_err - e0 !== 1) $display("FAIL timeout_err: pulses=%0d need 1", n_err - e0);
        else n_pass++;
        n_checks++;
        if (dt < 10000 || dt > 10250) $display("FAIL timeout_time: dt=%0t need 10000..10250", dt);
        else n_pass++;
        #12000;
        f = make_frame(N64_HEADER, 32'h0000_0001);
        send_bits(f, 41);
        model_frame(f);
        #2000;
        n_checks++;
        if (n_valid - v0 !== 1) $display("FAIL timeout_recover_valid: pulses=%0d need 1", n_valid - v0);
        else n_pass++;
        n_checks++;
        if (data !== exp_data) $display("FAIL timeout_recover_data: data=%h need %h", data, exp_data);
        else n_pass++;
        n_checks++;
        if (n_err - e0 !== 1) $display("FAIL timeout_single_err: pulses=%0d need 1", n_err - e0);
        else n_pass++;
    endtask

    task automatic test_glitch;
        int v0, e0, w;
        v0 = n_valid;
        e0 = n_err;
        w = $urandom_range(200, 2000);
        @(negedge clk);
        din = 1'b0;
        #(w);
        din = 1'b1;
        #15000;
        n_checks++;
        if (n_err - e0 !== 0 || n_valid - v0 !== 0)
            $display("FAIL glitch: err=%0d valid=%0d need 0/0 (width %0d)", n_err - e0, n_valid - v0, w);
        else n_pass++;
    endtask

    task automatic test_random_frame;
        int v0;
        logic [40:0] f;
        f = make_frame(N64_HEADER, $urandom);
        v0 = n_valid;
        send_bits(f, 41);
        model_frame(f);
        #2000;
        n_checks++;
        if (n_valid - v0 !== 1 || data !== exp_data)
            $display("FAIL random_frame: data=%h pulses=%0d need %h/1", data, n_valid - v0, exp_data);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame;
        int v0, e0, k;
        logic [40:0] f;
        f = make_frame(N64_HEADER, $urandom);
        k = $urandom_range(5, 35);
        send_bits(f, k);
        rst = 1'b1;
        exp_data = 32'h0;
        #1;
        n_checks++;
        if (data !== exp_data || valid !== 1'b0 || err !== 1'b0)
            $display("FAIL midreset_out: data=%h valid=%b err=%b need 0/0/0", data, valid, err);
        else n_pass++;
        #1000;
        rst = 1'b0;
        v0 = n_valid;
        e0 = n_err;
        #15000;
        n_checks++;
        if (n_err - e0 !== 0 || n_valid - v0 !== 0 || data !== exp_data)
            $display("FAIL midreset_quiet: err=%0d valid=%0d data=%h need 0/0/0", n_err - e0, n_valid - v0, data);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int v0, e0;
        logic [40:0] f;
        e0 = n_err;
        for (int i = 0; i < 2; i++) begin
            f = make_frame(N64_HEADER, (i == 0) ? 32'h8000_0000 : 32'h0020_0000);
            v0 = n_valid;
            send_bits(f, 41);
            model_frame(f);
            #2000;
            n_checks++;
            if (n_valid - v0 !== 1 || data !== exp_data)
                $display("FAIL b2b_frame%0d: data=%h pulses=%0d need %h/1", i, data, n_valid - v0, exp_data);
            else n_pass++;
            // Gap kept short so the run stays compact; decoder needs no minimum idle.
            #40000;
        end
        n_checks++;
        if (n_err - e0 !== 0) $display("FAIL b2b_err: pulses=%0d need 0", n_err - e0);
        else n_pass++;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_good_frame;
        test_bad_header;
        test_timeout;
        test_glitch;
        test_random_frame;
        test_reset_mid_frame;
        test_back_to_back;
        n_checks++;
        if (n_both !== 0) $display("FAIL valid_err_overlap: cycles=%0d need 0", n_both);
        else n_pass++;
        n_checks++;
        if (n_bad_change !== 0) $display("FAIL data_change_without_valid: cycles=%0d need 0", n_bad_change);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
